// File: rtl/opb_regbank_pkg.sv
// Shared types and helpers for the OPB register bank: FSM states, register modes, byte-lane mask.
// No logic of its own; latency and backpressure are set by the modules that import it.
package opb_regbank_pkg;

  typedef enum logic {IDLE, ACK} state_t;

  localparam logic [1:0] LEVEL = 2'd0;
  localparam logic [1:0] PULSE = 2'd1;
  localparam logic [1:0] RO    = 2'd2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < n) r = k + 1;
    end
    return r;
  endfunction

  // be[3] is OPB_BE[0] and covers register bits 31:24
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) begin
      m[8*k +: 8] = {8{be[k]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/opb_reg_cell.sv
// One 32-bit register (level, self-clearing pulse, or read-only capture) with byte-masked write.
// Write lands on the edge after wr_vld, strobe follows one cycle later; no backpressure.
module opb_reg_cell
  import opb_regbank_pkg::*;
#(
  parameter logic [1:0]  MODE      = LEVEL,
  parameter logic [31:0] RESET_VAL = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_vld,
  input  logic [3:0]  wr_be,
  input  logic [31:0] wr_dat,
  input  logic        rd_sample,
  input  logic [31:0] user_in,
  output logic [31:0] reg_dat,
  output logic [31:0] rd_dat,
  output logic        wr_stb
);

  logic [31:0] val_q;
  logic [31:0] shadow_q;
  logic [31:0] mask;
  logic [31:0] base;
  logic [31:0] merged;

  // a pulse register merges into the last written value, not the cleared one
  assign mask   = be_mask(wr_be);
  assign base   = (MODE == PULSE) ? shadow_q : val_q;
  assign merged = (base & ~mask) | (wr_dat & mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q    <= RESET_VAL;
      shadow_q <= RESET_VAL;
      wr_stb   <= 1'b0;
    end else begin
      wr_stb <= wr_vld && (MODE != RO);
      if (MODE == RO) begin
        if (rd_sample) shadow_q <= user_in;
      end else if (wr_vld) begin
        val_q    <= merged;
        shadow_q <= merged;
      end else if (MODE == PULSE) begin
        val_q <= RESET_VAL;
      end
    end
  end

  assign reg_dat = val_q;
  assign rd_dat  = (MODE == LEVEL) ? val_q : shadow_q;

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing C_NUM_REGS 32-bit registers (level / pulse / read-only) to user logic.
// Ack is seen by the master 2 edges after select rises; one transfer per 2 cycles; never stalls further.
module opb_register_bank_ppc2simulink
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h01003800,
  parameter logic [31:0] C_HIGHADDR   = 32'h010038FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 4,
  parameter logic [63:0] C_PULSE_MASK = '0,
  parameter logic [63:0] C_RO_MASK    = '0,
  parameter logic [C_NUM_REGS*32-1:0] C_RESET_VAL = '0
) (
  input  logic                       OPB_Clk,
  input  logic                       OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]    OPB_ABus,
  input  logic [0:3]                 OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]    OPB_DBus,
  input  logic                       OPB_RNW,
  input  logic                       OPB_select,
  input  logic                       OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]    Sl_DBus,
  output logic                       Sl_xferAck,
  output logic                       Sl_errAck,
  output logic                       Sl_retry,
  output logic                       Sl_toutSup,
  output logic [C_NUM_REGS*32-1:0]   user_data_out,
  output logic [C_NUM_REGS-1:0]      user_wr_stb,
  input  logic [C_NUM_REGS*32-1:0]   user_data_in
);

  localparam int IDX_W = (C_NUM_REGS > 1) ? clog2(C_NUM_REGS) : 1;

  typedef struct packed {
    logic             hole;
    logic [IDX_W-1:0] idx;
    logic             rnw;
    logic [3:0]       be;
    logic [31:0]      dat;
  } req_t;

  state_t      state_q, state_nxt;
  req_t        req_q;
  logic        cap_vld;
  logic        hit;
  logic [31:0] addr;
  logic [31:0] off;
  logic [29:0] word;
  logic        hole_d;
  logic [IDX_W-1:0] idx_d;
  logic        ack_vld;
  logic        wr_go;
  logic [31:0] rd_word;
  logic [31:0] rd_dat [C_NUM_REGS];
  logic        unused_ok;

  assign addr   = OPB_ABus;
  assign hit    = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign off    = addr - C_BASEADDR;
  assign word   = off[31:2];
  assign hole_d = (word >= 30'(C_NUM_REGS));
  assign idx_d  = word[IDX_W-1:0];
  assign unused_ok = ^{OPB_seqAddr, off[1:0]};

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) state_q <= IDLE;
    else         state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    cap_vld   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          state_nxt = ACK;
          cap_vld   = 1'b1;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      req_q <= '0;
    end else if (cap_vld) begin
      req_q <= '{hole: hole_d, idx: idx_d, rnw: OPB_RNW, be: OPB_BE, dat: OPB_DBus};
    end
  end

  // reset in the ack cycle drops the transfer: no ack seen, no write committed
  assign ack_vld = (state_q == ACK) && !OPB_Rst;
  assign wr_go   = ack_vld && !req_q.rnw && !req_q.hole;

  for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_reg
    localparam logic [1:0] MODE_I = C_RO_MASK[i]    ? RO :
                                    C_PULSE_MASK[i] ? PULSE : LEVEL;
    opb_reg_cell #(
      .MODE      (MODE_I),
      .RESET_VAL (C_RESET_VAL[32*i +: 32])
    ) u_cell (
      .clk       (OPB_Clk),
      .rst       (OPB_Rst),
      .wr_vld    (wr_go && (req_q.idx == IDX_W'(i))),
      .wr_be     (req_q.be),
      .wr_dat    (req_q.dat),
      .rd_sample (cap_vld && !hole_d && (idx_d == IDX_W'(i))),
      .user_in   (user_data_in[32*i +: 32]),
      .reg_dat   (user_data_out[32*i +: 32]),
      .rd_dat    (rd_dat[i]),
      .wr_stb    (user_wr_stb[i])
    );
  end

  assign rd_word    = rd_dat[req_q.idx];
  assign Sl_DBus    = (ack_vld && req_q.rnw && !req_q.hole) ? rd_word : '0;
  assign Sl_xferAck = ack_vld;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed bench for the OPB register bank: reg1 resets to DEADBEEF, reg2 pulse, reg3 read-only.
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE = 32'h01003800;

  logic         clk = 1'b0;
  logic         rst;
  logic [0:31]  abus;
  logic [0:3]   be;
  logic [0:31]  dbus;
  logic         rnw;
  logic         sel;
  logic         seq;
  logic [0:31]  sl_dbus;
  logic         ack;
  logic         err_ack;
  logic         retry;
  logic         tout_sup;
  logic [127:0] udo;
  logic [3:0]   stb;
  logic [127:0] udi;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_ack_cyc = 0;
  int prev_ack_cyc = 0;
  int leak = 0;
  logic [31:0] rd;
  int lat;

  opb_register_bank_ppc2simulink #(
    .C_NUM_REGS   (4),
    .C_PULSE_MASK (64'h4),
    .C_RO_MASK    (64'h8),
    .C_RESET_VAL  ({32'h0, 32'h0, 32'hDEADBEEF, 32'h0})
  ) dut (
    .OPB_Clk       (clk),
    .OPB_Rst       (rst),
    .OPB_ABus      (abus),
    .OPB_BE        (be),
    .OPB_DBus      (dbus),
    .OPB_RNW       (rnw),
    .OPB_select    (sel),
    .OPB_seqAddr   (seq),
    .Sl_DBus       (sl_dbus),
    .Sl_xferAck    (ack),
    .Sl_errAck     (err_ack),
    .Sl_retry      (retry),
    .Sl_toutSup    (tout_sup),
    .user_data_out (udo),
    .user_wr_stb   (stb),
    .user_data_in  (udi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!ack && sl_dbus != 32'h0) leak <= leak + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where ack is visible, select dropped.
  // lat counts posedges from select rising to the edge where the master samples ack.
  task automatic xfer(input logic [31:0] a, input logic r, input logic [3:0] b,
                      input logic [31:0] d, output logic [31:0] rdat, output int l);
    logic got;
    abus = a; rnw = r; be = b; dbus = d; sel = 1'b1;
    got = 1'b0; l = 0; rdat = '0;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clk);
      if (ack) begin
        got = 1'b1;
        l = k + 1;
        rdat = sl_dbus;
        last_ack_cyc = cyc;
      end
    end
    sel = 1'b0;
    chk("ack_seen", got, 1'b1);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; rnw = 1'b1; be = '0; abus = '0; dbus = '0; seq = 1'b0;
    udi = {32'hCAFE0003, 96'h0};
    repeat (3) @(negedge clk);
    chk("rst_ack",  ack, 1'b0);
    chk("rst_dbus", sl_dbus, 32'h0);
    chk("rst_stb",  stb, 4'h0);
    chk("rst_reg0", udo[31:0], 32'h0);
    chk("rst_reg1", udo[63:32], 32'hDEADBEEF);
    rst = 1'b0;
    @(negedge clk);

    xfer(BASE + 4, 1'b1, 4'hF, 32'h0, rd, lat);
    chk("rd1_lat", lat, 2);
    chk("rd1_dat", rd, 32'hDEADBEEF);
    @(negedge clk);

    xfer(BASE, 1'b0, 4'b0110, 32'h12345678, rd, lat);
    chk("wr0_lat", lat, 2);
    chk("wr0_stb_ack", stb, 4'h0);
    @(negedge clk);
    chk("wr0_stb", stb, 4'b0001);
    chk("wr0_val", udo[31:0], 32'h00345600);
    @(negedge clk);
    chk("wr0_stb_off", stb, 4'h0);
    chk("wr0_hold", udo[31:0], 32'h00345600);

    xfer(BASE + 8, 1'b0, 4'hF, 32'h1, rd, lat);
    @(negedge clk);
    chk("p2_stb", stb, 4'b0100);
    chk("p2_val", udo[95:64], 32'h1);
    @(negedge clk);
    chk("p2_clr", udo[95:64], 32'h0);
    chk("p2_stb_off", stb, 4'h0);
    xfer(BASE + 8, 1'b1, 4'hF, 32'h0, rd, lat);
    chk("p2_rd", rd, 32'h1);
    @(negedge clk);

    xfer(BASE + 12, 1'b0, 4'hF, 32'hFFFFFFFF, rd, lat);
    @(negedge clk);
    chk("ro_stb", stb, 4'h0);
    chk("ro_out", udo[127:96], 32'h0);
    xfer(BASE + 12, 1'b1, 4'hF, 32'h0, rd, lat);
    chk("ro_rd", rd, 32'hCAFE0003);
    @(negedge clk);

    seq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      xfer(BASE + 32'(4 * i), 1'b0, 4'hF, 32'h11111111 * (i + 1), rd, lat);
      if (i > 0) chk("burst_gap", last_ack_cyc - prev_ack_cyc, 2);
      prev_ack_cyc = last_ack_cyc;
    end
    seq = 1'b0;
    @(negedge clk);
    chk("burst_r0", udo[31:0], 32'h11111111);
    chk("burst_r1", udo[63:32], 32'h22222222);
    chk("burst_r2_clr", udo[95:64], 32'h0);
    chk("burst_r3", udo[127:96], 32'h0);
    xfer(BASE + 8, 1'b1, 4'hF, 32'h0, rd, lat);
    chk("burst_r2_rd", rd, 32'h33333333);

    xfer(BASE + 32'h40, 1'b1, 4'hF, 32'h0, rd, lat);
    chk("hole_lat", lat, 3);
    chk("hole_rd", rd, 32'h0);
    xfer(BASE + 32'h40, 1'b0, 4'hF, 32'hFFFFFFFF, rd, lat);
    @(negedge clk);
    chk("hole_stb", stb, 4'h0);
    chk("hole_r0", udo[31:0], 32'h11111111);

    xfer(BASE + 4, 1'b0, 4'b0000, 32'hFFFFFFFF, rd, lat);
    @(negedge clk);
    chk("be0_stb", stb, 4'b0010);
    chk("be0_val", udo[63:32], 32'h22222222);

    // reset lands while the FSM sits in ACK with a write pending
    @(negedge clk);
    abus = BASE + 4; rnw = 1'b0; be = 4'hF; dbus = 32'h55555555; sel = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_ack_drop", ack, 1'b0);
    @(negedge clk);
    chk("rst_stb_drop", stb, 4'h0);
    chk("rst_r0", udo[31:0], 32'h0);
    chk("rst_r1", udo[63:32], 32'hDEADBEEF);
    sel = 1'b0; rst = 1'b0;
    @(negedge clk);
    xfer(BASE + 8, 1'b1, 4'hF, 32'h0, rd, lat);
    chk("rst_r2_shadow", rd, 32'h0);
    xfer(BASE + 4, 1'b1, 4'hF, 32'h0, rd, lat);
    chk("rst_r1_rd", rd, 32'hDEADBEEF);

    @(negedge clk);
    chk("dbus_idle_zero", leak, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
